// File: rtl/crc16_rx_checker.sv
// Receive-side CRC-16 CCITT checker: strips the trailing two CRC bytes and reports per-frame status.
// Optional payload length counter / err_len check enabled by defining CRC16_RX_LEN_EN.
module crc16_rx_checker #(
    parameter int MAX_LEN = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        crc_ok,
    output logic [15:0] crc_residue,
    output logic [12:0] frame_len,
    output logic        err_runt,
    output logic        err_sync,
    output logic        err_len
);

    typedef enum logic [1:0] {IDLE, FILL, FWD} state_t;

    state_t      state_reg;
    logic [15:0] crc_reg;
    logic [7:0]  hold_old_reg;
    logic [7:0]  hold_new_reg;
    logic [1:0]  runt_cnt_reg;
    logic        emitted_reg;

    logic [15:0] crc_seed;
    logic [15:0] crc_next;
    logic [1:0]  runt_next;
    logic        abort_now;
    logic        runt_now;
    logic        end_now;
    logic        done_now;
    logic [15:0] res_d;
    logic        runt_d;
    logic        ok_d;
    logic        len_over;

    function automatic logic [15:0] crc_update(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    always_comb begin
        crc_seed  = (state_reg == IDLE || in_sof) ? 16'hFFFF : crc_reg;
        crc_next  = crc_update(crc_seed, in_data);
        runt_next = in_sof ? 2'd1 : ((runt_cnt_reg == 2'd3) ? 2'd3 : runt_cnt_reg + 2'd1);
        abort_now = in_valid && in_sof && (state_reg != IDLE);
        runt_now  = in_valid && in_sof && in_eof && (state_reg == IDLE);
        end_now   = in_valid && !in_sof && in_eof && (state_reg != IDLE);
        done_now  = abort_now || runt_now || end_now;
        res_d     = abort_now ? crc_reg : crc_next;
        runt_d    = abort_now ? (runt_cnt_reg < 2'd2) : (runt_next < 2'd2);
        ok_d      = !abort_now && (res_d == 16'h0000) && !runt_d && !len_over;
    end

`ifdef CRC16_RX_LEN_EN
    localparam logic [13:0] MAX_LEN_W = 14'(MAX_LEN);

    logic [12:0] pay_cnt_reg;
    logic [12:0] len_final;
    logic [12:0] frame_len_reg;
    logic        err_len_reg;
    logic        emit_now;

    // Payload count equals bytes emitted so far, saturating at the counter's ceiling.
    always_comb begin
        emit_now  = in_valid && !in_sof && (state_reg == FWD);
        len_final = (emit_now && pay_cnt_reg != 13'h1FFF) ? pay_cnt_reg + 13'd1 : pay_cnt_reg;
        len_over  = ({1'b0, len_final} > MAX_LEN_W);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pay_cnt_reg   <= '0;
            frame_len_reg <= '0;
            err_len_reg   <= 1'b0;
        end else begin
            if (in_valid && in_sof) begin
                pay_cnt_reg <= '0;
            end else if (in_valid && state_reg != IDLE) begin
                pay_cnt_reg <= in_eof ? 13'd0 : len_final;
            end
            if (done_now) begin
                frame_len_reg <= len_final;
                err_len_reg   <= len_over;
            end
        end
    end

    assign frame_len = frame_len_reg;
    assign err_len   = err_len_reg;
`else
    // Without a counter the known payload length is zero, which can only exceed a negative limit.
    assign len_over  = (MAX_LEN < 0);
    assign frame_len = '0;
    assign err_len   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            crc_reg      <= 16'hFFFF;
            hold_old_reg <= '0;
            hold_new_reg <= '0;
            runt_cnt_reg <= '0;
            emitted_reg  <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sof      <= 1'b0;
            out_eof      <= 1'b0;
            frame_done   <= 1'b0;
            crc_ok       <= 1'b0;
            crc_residue  <= '0;
            err_runt     <= 1'b0;
            err_sync     <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= done_now;

            if (done_now) begin
                crc_ok      <= ok_d;
                crc_residue <= res_d;
                err_runt    <= runt_d;
                err_sync    <= abort_now;
            end

            if (in_valid) begin
                if (in_sof) begin
                    // A sof+eof byte that also aborts a frame is dropped: only one status slot per cycle.
                    crc_reg      <= crc_next;
                    hold_new_reg <= in_data;
                    runt_cnt_reg <= runt_next;
                    emitted_reg  <= 1'b0;
                    state_reg    <= in_eof ? IDLE : FILL;
                end else if (state_reg != IDLE) begin
                    crc_reg      <= crc_next;
                    hold_old_reg <= hold_new_reg;
                    hold_new_reg <= in_data;
                    runt_cnt_reg <= runt_next;
                    if (state_reg == FWD) begin
                        out_valid   <= 1'b1;
                        out_data    <= hold_old_reg;
                        out_sof     <= !emitted_reg;
                        out_eof     <= in_eof;
                        emitted_reg <= 1'b1;
                    end
                    state_reg <= in_eof ? IDLE : FWD;
                end
            end
        end
    end

endmodule
